// File: rtl/a_buf_fill_ctrl_pkg.sv
// Shared types and constants for the A-operand ping-pong buffer controller.
// Holds array geometry defaults, element-width one-hot codes and the buffer state encoding.
package a_buf_fill_ctrl_pkg;

    localparam int SARRAY_H_DEF = 4;
    localparam int LOAD_W_DEF   = SARRAY_H_DEF * 32;

    localparam logic [2:0] W_1B = 3'b001;
    localparam logic [2:0] W_2B = 3'b010;
    localparam logic [2:0] W_4B = 3'b100;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        FILLING  = 2'd1,
        FULL     = 2'd2,
        DRAINING = 2'd3
    } buf_state_e;

    function automatic logic is_legal_width(input logic [2:0] w);
        return (w == W_1B) || (w == W_2B) || (w == W_4B);
    endfunction

    // Each row holds 4 bytes per column, so narrower elements need more beats.
    function automatic int unsigned beats_for_width(input logic [2:0] w, input int unsigned h);
        int unsigned n;
        case (w)
            W_1B:    n = 4 * h;
            W_2B:    n = 2 * h;
            W_4B:    n = h;
            default: n = 0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/a_buf_fill_ctrl_slot_state.sv
// One A buffer's lifecycle register: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
// Transition strobes arriving in the wrong state are ignored; state updates one cycle after the strobe.
module a_buf_slot_state
    import a_buf_fill_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_fill_start,
    input  logic       i_fill_done,
    input  logic       i_drain_start,
    input  logic       i_drain_done,
    output logic [1:0] o_state
);

    buf_state_e r_state;
    buf_state_e w_state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:    if (i_fill_start)  w_state_nxt = FILLING;
            FILLING:  if (i_fill_done)   w_state_nxt = FULL;
            FULL:     if (i_drain_start) w_state_nxt = DRAINING;
            DRAINING: if (i_drain_done)  w_state_nxt = EMPTY;
            default:                     w_state_nxt = EMPTY;
        endcase
    end

    assign o_state = r_state;

endmodule

// File: rtl/a_buf_fill_ctrl.sv
// Ping-pong fill/drain controller for the A buffers: beats -> registered writes (1 cycle), full buffer -> SARRAY_H read pulses.
// Backpressure via mem_ready_o/cmd_ready_o/drain_ready_o; A_BUF_FILL_PERF_EN adds stall/tile counters.
module a_buf_fill_ctrl
    import a_buf_fill_ctrl_pkg::*;
#(
    parameter int SARRAY_H = SARRAY_H_DEF,
    parameter int LOAD_W   = SARRAY_H * 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_width_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [LOAD_W-1:0] mem_data_i,
    output logic              wr_a_buf_valid_o,
    output logic              wr_a_buf_id_o,
    output logic [2:0]        wr_a_buf_data_width_o,
    output logic [LOAD_W-1:0] wr_a_buf_data_o,
    input  logic              drain_valid_i,
    output logic              drain_ready_o,
    output logic              rd_a_buf_valid_o,
    output logic              rd_a_buf_id_o,
    output logic              err_o
`ifdef A_BUF_FILL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt_o,
    output logic [31:0]       perf_tile_cnt_o
`endif
);

    localparam int CNT_W = $clog2(4 * SARRAY_H + 1);
    localparam int ROW_W = (SARRAY_H > 1) ? $clog2(SARRAY_H) : 1;

    logic              r_fill_ptr;
    logic              r_drain_ptr;
    logic              r_filling;
    logic              r_draining;
    logic [2:0]        r_width;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [CNT_W-1:0]  r_beats_total;
    logic [ROW_W-1:0]  r_row_cnt;
    logic              r_wr_vld;
    logic              r_wr_last;
    logic              r_wr_id;
    logic [2:0]        r_wr_width;
    logic [LOAD_W-1:0] r_wr_dat;
    logic              r_err;

    buf_state_e        w_state [2];
    logic              w_cmd_fire;
    logic              w_cmd_ok;
    logic              w_fill_go;
    logic              w_mem_fire;
    logic [CNT_W-1:0]  w_beat_nxt;
    logic              w_last_beat;
    logic              w_fill_end;
    logic              w_drain_fire;
    logic              w_drain_end;

    assign cmd_ready_o   = !r_filling && (w_state[r_fill_ptr] == EMPTY);
    assign w_cmd_fire    = cmd_valid_i && cmd_ready_o;
    assign w_cmd_ok      = is_legal_width(cmd_width_i);
    assign w_fill_go     = w_cmd_fire && w_cmd_ok;

    assign mem_ready_o   = r_filling && (r_beat_cnt < r_beats_total);
    assign w_mem_fire    = mem_valid_i && mem_ready_o;
    assign w_beat_nxt    = r_beat_cnt + 1'b1;
    assign w_last_beat   = w_mem_fire && (w_beat_nxt == r_beats_total);

    // The buffer turns FULL only once its last write has actually left the block.
    assign w_fill_end    = r_wr_vld && r_wr_last;

    assign drain_ready_o = !r_draining && (w_state[r_drain_ptr] == FULL);
    assign w_drain_fire  = drain_valid_i && drain_ready_o;
    assign w_drain_end   = r_draining && (r_row_cnt == ROW_W'(SARRAY_H - 1));

    for (genvar b = 0; b < 2; b++) begin : g_slot
        logic [1:0] w_st;

        a_buf_slot_state u_slot (
            .clk           (clk),
            .rst           (rst),
            .i_fill_start  (w_fill_go    && (r_fill_ptr  == 1'(b))),
            .i_fill_done   (w_fill_end   && (r_wr_id     == 1'(b))),
            .i_drain_start (w_drain_fire && (r_drain_ptr == 1'(b))),
            .i_drain_done  (w_drain_end  && (r_drain_ptr == 1'(b))),
            .o_state       (w_st)
        );

        assign w_state[b] = buf_state_e'(w_st);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_ptr    <= 1'b0;
            r_filling     <= 1'b0;
            r_width       <= '0;
            r_beat_cnt    <= '0;
            r_beats_total <= '0;
        end else begin
            if (w_fill_go) begin
                r_filling     <= 1'b1;
                r_width       <= cmd_width_i;
                r_beat_cnt    <= '0;
                r_beats_total <= CNT_W'(beats_for_width(cmd_width_i, SARRAY_H));
            end else if (w_mem_fire) begin
                r_beat_cnt    <= w_beat_nxt;
            end
            if (w_fill_end) begin
                r_filling  <= 1'b0;
                r_fill_ptr <= ~r_fill_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_vld   <= 1'b0;
            r_wr_last  <= 1'b0;
            r_wr_id    <= 1'b0;
            r_wr_width <= '0;
            r_wr_dat   <= '0;
            r_err      <= 1'b0;
        end else begin
            r_wr_vld  <= w_mem_fire;
            r_wr_last <= w_last_beat;
            if (w_mem_fire) begin
                r_wr_id    <= r_fill_ptr;
                r_wr_width <= r_width;
                r_wr_dat   <= mem_data_i;
            end
            // Illegal widths are consumed so the command stream cannot wedge.
            r_err <= w_cmd_fire && !w_cmd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_drain_ptr <= 1'b0;
            r_draining  <= 1'b0;
            r_row_cnt   <= '0;
        end else if (w_drain_fire) begin
            r_draining <= 1'b1;
            r_row_cnt  <= '0;
        end else if (r_draining) begin
            if (w_drain_end) begin
                r_draining  <= 1'b0;
                r_drain_ptr <= ~r_drain_ptr;
                r_row_cnt   <= '0;
            end else begin
                r_row_cnt <= r_row_cnt + 1'b1;
            end
        end
    end

    assign wr_a_buf_valid_o      = r_wr_vld;
    assign wr_a_buf_id_o         = r_wr_id;
    assign wr_a_buf_data_width_o = r_wr_width;
    assign wr_a_buf_data_o       = r_wr_dat;
    assign rd_a_buf_valid_o      = r_draining;
    assign rd_a_buf_id_o         = r_drain_ptr;
    assign err_o                 = r_err;

`ifdef A_BUF_FILL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_tile;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_tile  <= '0;
        end else begin
            if (r_filling && !mem_valid_i && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 1'b1;
            end
            if (w_drain_end && (r_perf_tile != '1)) begin
                r_perf_tile <= r_perf_tile + 1'b1;
            end
        end
    end

    assign perf_stall_cnt_o = r_perf_stall;
    assign perf_tile_cnt_o  = r_perf_tile;
`endif

endmodule

// File: tb/tb_a_buf_fill_ctrl.sv
// Directed bench for a_buf_fill_ctrl: a cycle table for one fill/drain, then hand sequences for corner cases.
module tb_a_buf_fill_ctrl;
    import a_buf_fill_ctrl_pkg::*;

    localparam int H  = 4;
    localparam int LW = H * 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_width;
    logic          mem_valid;
    logic          mem_ready;
    logic [LW-1:0] mem_data;
    logic          wr_v;
    logic          wr_id;
    logic [2:0]    wr_w;
    logic [LW-1:0] wr_d;
    logic          drain_valid;
    logic          drain_ready;
    logic          rd_v;
    logic          rd_id;
    logic          err;
`ifdef A_BUF_FILL_PERF_EN
    logic [31:0]   perf_stall;
    logic [31:0]   perf_tile;
`endif

    always #5 clk = ~clk;

    a_buf_fill_ctrl #(.SARRAY_H(H), .LOAD_W(LW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .cmd_valid_i           (cmd_valid),
        .cmd_ready_o           (cmd_ready),
        .cmd_width_i           (cmd_width),
        .mem_valid_i           (mem_valid),
        .mem_ready_o           (mem_ready),
        .mem_data_i            (mem_data),
        .wr_a_buf_valid_o      (wr_v),
        .wr_a_buf_id_o         (wr_id),
        .wr_a_buf_data_width_o (wr_w),
        .wr_a_buf_data_o       (wr_d),
        .drain_valid_i         (drain_valid),
        .drain_ready_o         (drain_ready),
        .rd_a_buf_valid_o      (rd_v),
        .rd_a_buf_id_o         (rd_id),
        .err_o                 (err)
`ifdef A_BUF_FILL_PERF_EN
        ,
        .perf_stall_cnt_o      (perf_stall),
        .perf_tile_cnt_o       (perf_tile)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       cmd_v;
        logic [2:0] cmd_w;
        logic       mem_v;
        logic [7:0] mem_d;
        logic       drn_v;
        logic       e_cmd_rdy;
        logic       e_mem_rdy;
        logic       e_wr_v;
        logic [7:0] e_wr_d;
        logic       e_drn_rdy;
        logic       e_rd_v;
        logic       e_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cmd_valid   = 1'b0;
        cmd_width   = 3'b000;
        mem_valid   = 1'b0;
        mem_data    = '0;
        drain_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    // Loads one 4-byte tile; reports the buffer id the writes went to.
    task automatic fill_4b(input int base, output logic id_seen);
        int g;
        int sent;
        id_seen   = 1'bx;
        cmd_valid = 1'b1;
        cmd_width = W_4B;
        g = 0;
        @(negedge clk);
        while (!cmd_ready && g < 50) begin
            step();
            @(negedge clk);
            g++;
        end
        step();
        cmd_valid = 1'b0;
        sent = 0;
        g = 0;
        while ((sent < H || wr_v) && g < 50) begin
            mem_valid = (sent < H);
            mem_data  = LW'(base + sent);
            @(negedge clk);
            if (mem_valid && mem_ready) sent++;
            if (wr_v) id_seen = wr_id;
            step();
            g++;
        end
        mem_valid = 1'b0;
        chk("fill4_beats", sent, H);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   acc;
        int   wrc;
        int   bad;
        int   stall;
        int   overlap;
        int   both;
        int   rd0;
        logic idx;

        //            cmd_v cmd_w  mem_v mem_d drn | cmd_rdy mem_rdy wr_v wr_d drn_rdy rd_v err
        tbl[0]  = '{1'b1, W_4B,   1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'b000, 1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'b000, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 3'b000, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 3'b000, 1'b1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'b000, 1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 3'b000, 1'b0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 3'b000, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 3'b000, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 3'b000, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'b000, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 3'b000, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_cmd_rdy", cmd_ready, 1'b1);
        chk("rst_mem_rdy", mem_ready, 1'b0);
        chk("rst_drn_rdy", drain_ready, 1'b0);
        chk("rst_wr_v", wr_v, 1'b0);
        chk("rst_wr_d", wr_d, '0);
        chk("rst_rd_v", rd_v, 1'b0);
        chk("rst_err", err, 1'b0);
`ifdef A_BUF_FILL_PERF_EN
        chk("rst_perf_stall", perf_stall, 0);
        chk("rst_perf_tile", perf_tile, 0);
`endif
        step();

        // Cycle table: 4B fill of buffer 0 then its drain
        for (int i = 0; i < 12; i++) begin
            cmd_valid   = tbl[i].cmd_v;
            cmd_width   = tbl[i].cmd_w;
            mem_valid   = tbl[i].mem_v;
            mem_data    = LW'(tbl[i].mem_d);
            drain_valid = tbl[i].drn_v;
            @(negedge clk);
            chk($sformatf("t%0d_cmd_rdy", i), cmd_ready, tbl[i].e_cmd_rdy);
            chk($sformatf("t%0d_mem_rdy", i), mem_ready, tbl[i].e_mem_rdy);
            chk($sformatf("t%0d_wr_v", i), wr_v, tbl[i].e_wr_v);
            chk($sformatf("t%0d_drn_rdy", i), drain_ready, tbl[i].e_drn_rdy);
            chk($sformatf("t%0d_rd_v", i), rd_v, tbl[i].e_rd_v);
            chk($sformatf("t%0d_err", i), err, tbl[i].e_err);
            if (tbl[i].e_wr_v) begin
                chk($sformatf("t%0d_wr_d", i), wr_d, LW'(tbl[i].e_wr_d));
                chk($sformatf("t%0d_wr_id", i), wr_id, 1'b0);
                chk($sformatf("t%0d_wr_w", i), wr_w, W_4B);
            end
            if (tbl[i].e_rd_v) chk($sformatf("t%0d_rd_id", i), rd_id, 1'b0);
            step();
        end
        clear_inputs();

        // 1-byte fill: 16 beats accepted, 17th held
        do_reset();
        cmd_valid = 1'b1;
        cmd_width = W_1B;
        @(negedge clk);
        chk("b1_cmd_rdy", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        acc = 0;
        wrc = 0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            mem_valid = 1'b1;
            mem_data  = LW'(c + 1);
            @(negedge clk);
            if (mem_ready) acc++;
            if (wr_v) begin
                wrc++;
                if (wr_id !== 1'b0 || wr_w !== W_1B || wr_d !== LW'(wrc)) bad++;
            end
            step();
        end
        @(negedge clk);
        chk("b1_17th_held", mem_ready, 1'b0);
        chk("b1_beats", acc, 16);
        chk("b1_writes", wrc, 16);
        chk("b1_write_fields", bad, 0);
        chk("b1_full_drn_rdy", drain_ready, 1'b1);
        chk("b1_next_cmd_rdy", cmd_ready, 1'b1);
        step();
        mem_valid = 1'b0;

        // Second fill lands in buffer 1; both FULL blocks commands
        fill_4b(32'h40, idx);
        chk("two_fill_id", idx, 1'b1);
        @(negedge clk);
        chk("both_full_cmd_rdy", cmd_ready, 1'b0);
        chk("both_full_drn_rdy", drain_ready, 1'b1);
        step();

        // Two back-to-back drains
        drain_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            logic er;
            logic eid;
            er  = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
            eid = (c >= 6);
            @(negedge clk);
            chk($sformatf("dd%0d_rd_v", c), rd_v, er);
            if (er) chk($sformatf("dd%0d_rd_id", c), rd_id, eid);
            chk($sformatf("dd%0d_cmd_rdy", c), cmd_ready, (c >= 5));
            step();
        end
        drain_valid = 1'b0;
`ifdef A_BUF_FILL_PERF_EN
        @(negedge clk);
        chk("perf_tile_two", perf_tile, 2);
        step();
`endif

        // Fill buffer 1 while buffer 0 drains
        do_reset();
        fill_4b(32'h10, idx);
        chk("conc_fill0_id", idx, 1'b0);
        cmd_valid   = 1'b1;
        cmd_width   = W_4B;
        drain_valid = 1'b1;
        @(negedge clk);
        chk("conc_cmd_rdy", cmd_ready, 1'b1);
        chk("conc_drn_rdy", drain_ready, 1'b1);
        step();
        cmd_valid   = 1'b0;
        drain_valid = 1'b0;
        acc = 0; wrc = 0; rd0 = 0; stall = 0; overlap = 0; both = 0;
        for (int c = 0; c < 8; c++) begin
            mem_valid = (acc < H);
            mem_data  = LW'(32'h20 + acc);
            @(negedge clk);
            if (mem_valid && !mem_ready) stall++;
            if (mem_valid && mem_ready) acc++;
            if (wr_v && wr_id === 1'b1) wrc++;
            if (rd_v && rd_id === 1'b0) rd0++;
            if (wr_v && rd_v) both++;
            if (wr_v && rd_v && wr_id === rd_id) overlap++;
            step();
        end
        mem_valid = 1'b0;
        chk("conc_beats", acc, H);
        chk("conc_stall", stall, 0);
        chk("conc_wr_id1", wrc, H);
        chk("conc_rd_id0", rd0, H);
        chk("conc_both_cycles", both, 3);
        chk("conc_id_overlap", overlap, 0);

        // Illegal widths
        do_reset();
        cmd_valid = 1'b1;
        cmd_width = 3'b011;
        @(negedge clk);
        chk("err_cmd_rdy", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse", err, 1'b1);
        chk("err_cmd_rdy_after", cmd_ready, 1'b1);
        chk("err_mem_rdy", mem_ready, 1'b0);
        chk("err_no_write", wr_v, 1'b0);
        step();
        @(negedge clk);
        chk("err_one_cycle", err, 1'b0);
        cmd_valid = 1'b1;
        cmd_width = 3'b000;
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("err_zero_width", err, 1'b1);
        chk("err_zero_mem_rdy", mem_ready, 1'b0);
        step();
        cmd_valid = 1'b1;
        cmd_width = W_2B;
        @(negedge clk);
        chk("err_next_cmd_rdy", cmd_ready, 1'b1);
        step();
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("err_next_accepted", mem_ready, 1'b1);
        chk("err_next_no_err", err, 1'b0);
        step();
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            mem_valid = 1'b1;
            @(negedge clk);
            if (mem_ready) acc++;
            step();
        end
        mem_valid = 1'b0;
        chk("b2_beats", acc, 2 * H);

        // Reset in the middle of a fill
        do_reset();
        cmd_valid = 1'b1;
        cmd_width = W_4B;
        step();
        cmd_valid = 1'b0;
        mem_valid = 1'b1;
        mem_data  = LW'(1);
        step();
        mem_data  = LW'(2);
        rst       = 1'b1;
        @(negedge clk);
        chk("mid_rst_wr_before", wr_v, 1'b1);
        step();
        rst       = 1'b0;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_wr_v", wr_v, 1'b0);
        chk("mid_rst_rd_v", rd_v, 1'b0);
        chk("mid_rst_cmd_rdy", cmd_ready, 1'b1);
        chk("mid_rst_drn_rdy", drain_ready, 1'b0);
        chk("mid_rst_mem_rdy", mem_ready, 1'b0);
        chk("mid_rst_err", err, 1'b0);
`ifdef A_BUF_FILL_PERF_EN
        chk("mid_rst_perf_stall", perf_stall, 0);
        chk("mid_rst_perf_tile", perf_tile, 0);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/a_buf_fill_ctrl.md
# a_buf_fill_ctrl

Ping-pong fill/drain controller for the A-operand buffer of the systolic array. It accepts tile-load commands, streams memory response beats into one of the two A buffers with the correct shift width, and tracks each buffer through EMPTY/FILLING/FULL/DRAINING. It also issues the row-by-row read pulses that push a full buffer into the array. It sits between the load/DMA response path (upstream) and a_buf (downstream, write and read ports).

## Interface
- SARRAY_H, 4: systolic array height/width; rows per buffer, 32-bit shift registers per row.
- LOAD_W, SARRAY_H*32: memory beat / a_buf write width in bits.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid_i / cmd_ready_o  in/out  1  tile-load command handshake.
- cmd_width_i  in  3  one-hot element width: [0]=1 byte, [1]=2 bytes, [2]=4 bytes.
- mem_valid_i / mem_ready_o  in/out  1  memory beat handshake.
- mem_data_i  in  LOAD_W  beat payload, forwarded unchanged.
- wr_a_buf_valid_o  out  1  a_buf write strobe.
- wr_a_buf_id_o  out  1  target buffer.
- wr_a_buf_data_width_o  out  3  shift mode.
- wr_a_buf_data_o  out  LOAD_W  write data.
- drain_valid_i / drain_ready_o  in/out  1  array-side request to consume the next full buffer.
- rd_a_buf_valid_o  out  1  a_buf read/shift-up strobe.
- rd_a_buf_id_o  out  1  buffer being drained.
- err_o  out  1  one-cycle pulse on an illegal command width.

## Operation
- Per-buffer state: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. Pointers fill_ptr and drain_ptr each toggle after their operation completes.
- Command acceptance:
  - cmd_ready_o = !filling_active & state[fill_ptr]==EMPTY.
  - On accept with a one-hot width: latch the width, state[fill_ptr]=FILLING, beat_cnt=0, beats_total = SARRAY_H*4/bytes (1B: 4*SARRAY_H, 2B: 2*SARRAY_H, 4B: SARRAY_H).
  - Non-one-hot width (including 0): the command is accepted and dropped, err_o pulses, and no state changes.
- mem_ready_o = filling_active & beat_cnt < beats_total.
- Each accepted beat registers wr_a_buf_valid_o=1 with id=fill_ptr, the latched width and the data. beat_cnt increments.
- After the last beat: state[fill_ptr]=FULL, fill_ptr toggles, filling_active clears.
- drain_ready_o = !draining_active & state[drain_ptr]==FULL.
- On drain accept: state=DRAINING and row_cnt=0. Then exactly SARRAY_H consecutive cycles of rd_a_buf_valid_o=1 with id=drain_ptr. After the last pulse: state=EMPTY, drain_ptr toggles.
- Fill and drain run concurrently on opposite buffers. A buffer never gets writes while FULL/DRAINING, or reads while EMPTY/FILLING.

## Timing
- Reset: all states EMPTY, pointers 0, counters 0. Every output is 0 except mem_ready_o=0, cmd_ready_o=1, drain_ready_o=0.
- Beat-to-write latency: 1 cycle; the write is registered.
- Back-to-back beats: full throughput, one per cycle.
- FULL becomes visible (drain_ready_o=1) the cycle after the last wr_a_buf_valid_o. The first rd pulse is registered one cycle after drain accept.
- EMPTY becomes visible the cycle after the last rd pulse. There is no same-cycle bypass, so a command waiting on that buffer is accepted one cycle later.
- Both buffers FULL: cmd_ready_o=0 until a drain completes.
- mem_valid_i while not filling: no handshake (ready=0), and the beat is held upstream.
- Reset mid-fill or mid-drain: all in-flight state is discarded and strobes deassert on the next cycle.

## Configuration
- A_BUF_FILL_PERF_EN defined adds two outputs, perf_stall_cnt_o[31:0] and perf_tile_cnt_o[31:0]. Both are saturating and cleared by rst.
  - perf_stall_cnt_o counts cycles with filling_active & !mem_valid_i.
  - perf_tile_cnt_o counts completed drains.
- A_BUF_FILL_PERF_EN undefined: the ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds: SARRAY_H/LOAD_W defaults, the width one-hot encodings (W_1B, W_2B, W_4B), the buf_state enum (EMPTY/FILLING/FULL/DRAINING), and a beats_for_width function.
- One sub-module: a_buf_slot_state. It holds one buffer's state register and its legal transitions, and is instantiated twice.

## Test plan
- SARRAY_H=4, cmd width 3'b100, 4 beats with data 0x1..0x4 -> wr strobes one cycle later carrying id 0, width 3'b100 and that data; drain_ready_o rises the cycle after the 4th write.
- cmd width 3'b001 -> 16 beats accepted, the 17th is held (mem_ready_o=0); buffer 0 FULL, fill_ptr=1.
- Two fills, then two drains -> rd pulses 4 cycles with id 0, then 4 cycles with id 1; cmd_ready_o stays 0 until the first drain ends, then is 1 one cycle later.
- Fill of buffer 1 concurrent with drain of buffer 0 -> interleaved wr (id 1) and rd (id 0) strobes with no stall and no id overlap.
- cmd width 3'b011 -> err_o pulses 1 cycle, no writes, state unchanged, next valid command accepted.
- rst asserted at beat 2 of a fill -> next cycle all strobes 0, cmd_ready_o=1, drain_ready_o=0; with A_BUF_FILL_PERF_EN, both counters read 0.
